// File: rtl/l1mtx_arb_param.sv
// Output-stage arbiter for the L1 AHB bus matrix: picks which of NUM_PORTS input stages owns the slave.
// Grant is one HREADYM-qualified edge after request; all state is frozen while HREADYM is low.
module l1mtx_arb_param #(
  parameter int NUM_PORTS        = 4,
  parameter int PORT_W           = 2,
  parameter int ARB_MODE         = 0,
  parameter int INCR_BEATS       = 4,
  parameter int EARLY_INCR_LIMIT = 1
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic [NUM_PORTS-1:0] port_en,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port,
  output logic [NUM_PORTS-1:0] grant_onehot,
  output logic                 hold_active
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  logic [NUM_PORTS-1:0] r;
  logic [3:0]           remain;
  logic [3:0]           next_remain;
  logic                 reg_burst_hold;
  logic                 next_hold;
  logic [1:0]           early_cnt;
  logic [1:0]           next_early;
  logic [PORT_W-1:0]    next_addr;
  logic                 next_no_port;
  logic                 found;
  int                   p;

  assign r           = req_port & port_en;
  assign hold_active = reg_burst_hold;

  always_comb begin
    next_remain = 4'd0;
    next_hold   = 1'b0;
    if (HSELM) begin
      case (HTRANSM)
        TR_NONSEQ: begin
          case (HBURSTM)
            3'b110, 3'b111: begin next_remain = 4'd14; next_hold = 1'b1; end
            3'b100, 3'b101: begin next_remain = 4'd6;  next_hold = 1'b1; end
            3'b010, 3'b011: begin next_remain = 4'd2;  next_hold = 1'b1; end
            3'b001: begin
              // Repeated early-terminated INCR bursts stop earning a hold.
              if (early_cnt != 2'(EARLY_INCR_LIMIT)) begin
                next_remain = 4'(INCR_BEATS - 2);
                next_hold   = 1'b1;
              end
            end
            default: ;
          endcase
        end
        TR_SEQ: begin
          if (remain != 4'd0) begin
            next_remain = remain - 4'd1;
            next_hold   = reg_burst_hold;
          end
        end
        TR_BUSY: begin
          next_remain = remain;
          next_hold   = reg_burst_hold;
        end
        TR_IDLE: ;
        default: ;
      endcase
    end
  end

  always_comb begin
    next_early = early_cnt;
    if (!next_hold)
      next_early = 2'd0;
    else if (reg_burst_hold && HTRANSM == TR_NONSEQ && early_cnt != 2'd3)
      next_early = early_cnt + 2'd1;
  end

  always_comb begin
    next_addr    = addr_in_port;
    next_no_port = no_port;
    found        = 1'b0;
    p            = int'(addr_in_port);
    if (HMASTLOCKM || next_hold) begin
      next_addr    = addr_in_port;
    end else if (no_port) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!found && r[PORT_W'(i)]) begin
          found        = 1'b1;
          next_addr    = PORT_W'(i);
          next_no_port = 1'b0;
        end
      end
    end else if (ARB_MODE == 0) begin
      for (int k = 1; k < NUM_PORTS; k++) begin
        if (!found && r[PORT_W'((p + k >= NUM_PORTS) ? p + k - NUM_PORTS : p + k)]) begin
          found     = 1'b1;
          next_addr = PORT_W'((p + k >= NUM_PORTS) ? p + k - NUM_PORTS : p + k);
        end
      end
      if (!found && !HSELM)
        next_no_port = 1'b1;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!found && i < p && r[PORT_W'(i)]) begin
          found     = 1'b1;
          next_addr = PORT_W'(i);
        end
      end
      // The current owner outranks any higher-index requester while it still selects the slave.
      if (!found && HSELM)
        found = 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!found && i > p && r[PORT_W'(i)]) begin
          found     = 1'b1;
          next_addr = PORT_W'(i);
        end
      end
      if (!found)
        next_no_port = 1'b1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_in_port   <= '0;
      no_port        <= 1'b1;
      reg_burst_hold <= 1'b0;
      remain         <= 4'd0;
      early_cnt      <= 2'd0;
    end else if (HREADYM) begin
      addr_in_port   <= next_addr;
      no_port        <= next_no_port;
      reg_burst_hold <= next_hold;
      remain         <= next_remain;
      early_cnt      <= next_early;
    end
  end

  always_comb begin
    grant_onehot = '0;
    if (!no_port)
      grant_onehot[addr_in_port] = 1'b1;
  end

endmodule

// File: tb/tb_l1mtx_arb_param.sv
// Bench for l1mtx_arb_param: round-robin and fixed-priority instances share stimulus,
// a behavioural model feeds a scoreboard queue, directed checks pin the key scenarios.
module tb_l1mtx_arb_param;

  localparam logic [1:0] IDLE = 2'b00, NS = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR = 3'b001, INCR8 = 3'b101;

  typedef struct packed {
    logic [1:0] addr;
    logic       nop;
    logic       hold;
    logic [3:0] rem;
    logic [1:0] early;
  } st_t;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [3:0] req_port, port_en;
  logic       HREADYM, HSELM, HMASTLOCKM;
  logic [1:0] HTRANSM;
  logic [2:0] HBURSTM;
  logic [1:0] a0, a1;
  logic       np0, np1, h0, h1;
  logic [3:0] g0, g1;

  int   n_vec = 0;
  int   n_err = 0;
  st_t  m0, m1, e;
  st_t  sb[$];
  int   rot_exp[5] = '{0, 1, 2, 3, 0};

  always #5 HCLK = ~HCLK;

  l1mtx_arb_param #(.NUM_PORTS(4), .PORT_W(2), .ARB_MODE(0), .INCR_BEATS(4), .EARLY_INCR_LIMIT(1)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port), .port_en(port_en),
    .HREADYM(HREADYM), .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM),
    .HMASTLOCKM(HMASTLOCKM), .addr_in_port(a0), .no_port(np0),
    .grant_onehot(g0), .hold_active(h0));

  l1mtx_arb_param #(.NUM_PORTS(4), .PORT_W(2), .ARB_MODE(1), .INCR_BEATS(4), .EARLY_INCR_LIMIT(1)) dut1 (
    .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port), .port_en(port_en),
    .HREADYM(HREADYM), .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM),
    .HMASTLOCKM(HMASTLOCKM), .addr_in_port(a1), .no_port(np1),
    .grant_onehot(g1), .hold_active(h1));

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic st_t mdl(st_t s, int mode, logic [3:0] rq, logic [3:0] en, logic rdy,
                              logic sel, logic [1:0] tr, logic [2:0] bu, logic lk);
    st_t        n;
    logic [3:0] r;
    logic       nh;
    logic [3:0] nr;
    bit         hit;
    int         idx;
    n = s;
    if (!rdy) return s;
    r  = rq & en;
    nh = 1'b0;
    nr = 4'd0;
    if (sel) begin
      if (tr == NS) begin
        if (bu >= 3'd6)       begin nr = 14; nh = 1; end
        else if (bu >= 3'd4)  begin nr = 6;  nh = 1; end
        else if (bu >= 3'd2)  begin nr = 2;  nh = 1; end
        else if (bu == INCR && s.early != 2'd1) begin nr = 2; nh = 1; end
      end else if (tr == SEQ) begin
        if (s.rem != 0) begin nr = s.rem - 1; nh = s.hold; end
      end else if (tr == 2'b01) begin
        nr = s.rem; nh = s.hold;
      end
    end
    n.rem  = nr;
    n.hold = nh;
    if (!nh) n.early = 0;
    else if (s.hold && tr == NS && s.early != 3) n.early = s.early + 1;
    hit = 0;
    if (lk || nh) begin
      hit = 1;
    end else if (s.nop) begin
      for (int i = 0; i < 4; i++)
        if (!hit && r[i]) begin hit = 1; n.addr = 2'(i); n.nop = 0; end
    end else if (mode == 0) begin
      for (int k = 1; k < 4; k++) begin
        idx = (int'(s.addr) + k) % 4;
        if (!hit && r[idx]) begin hit = 1; n.addr = 2'(idx); end
      end
      if (!hit && !sel) n.nop = 1;
    end else begin
      for (int i = 0; i < int'(s.addr); i++)
        if (!hit && r[i]) begin hit = 1; n.addr = 2'(i); end
      if (!hit && sel) hit = 1;
      for (int i = int'(s.addr) + 1; i < 4; i++)
        if (!hit && r[i]) begin hit = 1; n.addr = 2'(i); end
      if (!hit) n.nop = 1;
    end
    return n;
  endfunction

  task automatic cmp_out(input string tag, input st_t x, input logic [1:0] a, input logic np,
                         input logic [3:0] g, input logic h);
    chk({tag, ".addr"}, int'(a), int'(x.addr));
    chk({tag, ".no_port"}, int'(np), int'(x.nop));
    chk({tag, ".onehot"}, int'(g), x.nop ? 0 : int'(4'b0001 << x.addr));
    chk({tag, ".hold"}, int'(h), int'(x.hold));
  endtask

  task automatic step(input logic [3:0] rq, input logic rdy, input logic sel,
                      input logic [1:0] tr, input logic [2:0] bu, input logic lk);
    req_port = rq; HREADYM = rdy; HSELM = sel; HTRANSM = tr; HBURSTM = bu; HMASTLOCKM = lk;
    sb.push_back(mdl(m0, 0, rq, port_en, rdy, sel, tr, bu, lk));
    sb.push_back(mdl(m1, 1, rq, port_en, rdy, sel, tr, bu, lk));
    @(posedge HCLK);
    #1;
    e = sb.pop_front(); cmp_out("rr", e, a0, np0, g0, h0); m0 = e;
    e = sb.pop_front(); cmp_out("fp", e, a1, np1, g1, h1); m1 = e;
  endtask

  initial begin
    m0 = '{addr: 2'd0, nop: 1'b1, hold: 1'b0, rem: 4'd0, early: 2'd0};
    m1 = m0;
    HRESET = 1'b1; req_port = 4'b0000; port_en = 4'b0000; HREADYM = 1'b1;
    HSELM = 1'b0; HTRANSM = IDLE; HBURSTM = SINGLE; HMASTLOCKM = 1'b0;
    #12;
    chk("rst.addr", int'(a0), 0);
    chk("rst.no_port", int'(np0), 1);
    chk("rst.onehot", int'(g0), 0);
    chk("rst.hold", int'(h1), 0);
    HRESET = 1'b0;

    // All ports masked: nothing may be granted.
    repeat (2) step(4'b1111, 1, 0, IDLE, SINGLE, 0);
    chk("mask.no_port", int'(np0), 1);

    port_en = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1, 1, NS, SINGLE, 0);
      chk("rot.seq", int'(a0), rot_exp[i]);
    end
    repeat (3) step(4'b1111, 1, 1, NS, SINGLE, 0);
    chk("rot.at3", int'(a0), 3);
    repeat (2) begin
      step(4'b1111, 1, 1, NS, SINGLE, 1);
      chk("lock.keep", int'(a0), 3);
    end

    step(4'b0100, 1, 0, IDLE, SINGLE, 0);
    chk("fp.to2", int'(a1), 2);
    step(4'b0010, 1, 1, NS, SINGLE, 0);
    chk("fp.lower", int'(a1), 1);
    step(4'b0100, 1, 0, IDLE, SINGLE, 0);
    step(4'b1000, 1, 1, NS, SINGLE, 0);
    chk("fp.keep", int'(a1), 2);

    step(4'b0010, 1, 1, NS, SINGLE, 0);
    chk("incr8.own", int'(a0), 1);
    step(4'b1111, 1, 1, NS, INCR8, 0);
    chk("incr8.b1", int'(a0), 1);
    repeat (3) begin
      step(4'b1111, 1, 1, SEQ, INCR8, 0);
      chk("incr8.seq", int'(a0), 1);
    end
    repeat (3) step(4'b1111, 0, 1, SEQ, INCR8, 0);
    chk("incr8.frozen", int'(h0), 1);
    repeat (3) begin
      step(4'b1111, 1, 1, SEQ, INCR8, 0);
      chk("incr8.seq2", int'(a0), 1);
    end
    step(4'b1111, 1, 1, SEQ, INCR8, 0);
    chk("incr8.rearb", int'(a0), 2);
    chk("incr8.drop", int'(h0), 0);

    step(4'b0001, 1, 1, NS, SINGLE, 0);
    step(4'b1111, 1, 1, NS, INCR, 0);
    chk("early.first", int'(h0), 1);
    step(4'b1111, 1, 1, SEQ, INCR, 0);
    step(4'b1111, 1, 1, NS, INCR, 0);
    chk("early.second", int'(h0), 1);
    step(4'b1111, 1, 1, SEQ, INCR, 0);
    step(4'b1111, 1, 1, NS, INCR, 0);
    chk("early.nohold", int'(h0), 0);
    chk("early.grant", int'(a0), 1);

    step(4'b0100, 1, 1, NS, SINGLE, 0);
    step(4'b1111, 1, 1, NS, INCR8, 0);
    step(4'b1111, 1, 1, SEQ, INCR8, 0);
    chk("pre_rst.addr", int'(a0), 2);
    #2 HRESET = 1'b1;
    #1;
    chk("arst.addr", int'(a0), 0);
    chk("arst.no_port", int'(np0), 1);
    chk("arst.hold", int'(h0), 0);
    chk("arst.onehot", int'(g0), 0);
    #1 HRESET = 1'b0;
    m0 = '{addr: 2'd0, nop: 1'b1, hold: 1'b0, rem: 4'd0, early: 2'd0};
    m1 = m0;
    step(4'b1010, 1, 1, NS, SINGLE, 0);
    chk("post_rst.grant", int'(a0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
